// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// B0 flag layout, FSM states and coordinate/delta widths.
package mouse_pkg;

   localparam int COORD_W = 12;
   localparam int DELTA_W = 9;

   localparam int B0_LEFT  = 0;
   localparam int B0_RIGHT = 1;
   localparam int B0_MID   = 2;
   localparam int B0_SYNC  = 3;
   localparam int B0_XSIGN = 4;
   localparam int B0_YSIGN = 5;
   localparam int B0_XOVF  = 6;
   localparam int B0_YOVF  = 7;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2,
      APPLY   = 2'd3
   } state_t;

   // B0 without the always-one sync bit, which carries no information once accepted.
   typedef struct packed {
      logic yovf;
      logic xovf;
      logic ysign;
      logic xsign;
      logic mid;
      logic right;
      logic left;
   } b0_flags_t;

   function automatic b0_flags_t b0_unpack(input logic [7:0] b);
      b0_flags_t f;
      f.yovf  = b[B0_YOVF];
      f.xovf  = b[B0_XOVF];
      f.ysign = b[B0_YSIGN];
      f.xsign = b[B0_XSIGN];
      f.mid   = b[B0_MID];
      f.right = b[B0_RIGHT];
      f.left  = b[B0_LEFT];
      return f;
   endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One axis of position integration: adds (or subtracts) a 9-bit signed delta
// and clamps the result to [0, MAX]. Purely combinational; the parent registers it.
module mouse_axis_accum
   import mouse_pkg::*;
#(
   parameter int MAX = 799
) (
   input  logic [COORD_W-1:0] pos,
   input  logic [DELTA_W-1:0] delta,
   input  logic               ovf,
   input  logic               negate,
   output logic [COORD_W-1:0] next_pos
);

   localparam logic signed [COORD_W:0] MAX_S = (COORD_W+1)'(MAX);

   logic signed [COORD_W:0] pos_s;
   logic signed [COORD_W:0] delta_s;
   logic signed [COORD_W:0] sum;

   // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
   always_comb begin
      pos_s    = $signed({1'b0, pos});
      delta_s  = ovf ? '0 : $signed({{(COORD_W+1-DELTA_W){delta[DELTA_W-1]}}, delta});
      sum      = negate ? (pos_s - delta_s) : (pos_s + delta_s);
      next_pos = sum[COORD_W-1:0];
      if (sum < 0)
         next_pos = '0;
      else if (sum > MAX_S)
         next_pos = MAX_S[COORD_W-1:0];
   end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets and integrates them into clamped absolute
// screen coordinates and button state, all registered in the pclk domain.
module mouse_packet_decoder
   import mouse_pkg::*;
#(
   parameter int MAX_X       = 799,
   parameter int MAX_Y       = 599,
   parameter int INIT_X      = 400,
   parameter int INIT_Y      = 300,
   parameter int TIMEOUT_CYC = 80000
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   input  logic               rx_err,
   output logic [COORD_W-1:0] mouse_xpos,
   output logic [COORD_W-1:0] mouse_ypos,
   output logic               mouse_left,
   output logic               mouse_right,
   output logic               mouse_middle,
   output logic               pkt_valid
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             ld_b0, ld_b1, ld_b2, do_apply;

   b0_flags_t        b0_q;
   logic [7:0]       b1_q, b2_q;
   logic [COORD_W-1:0] x_next, y_next;

   always_comb begin
      state_d  = state_q;
      tmo_d    = '0;
      ld_b0    = 1'b0;
      ld_b1    = 1'b0;
      ld_b2    = 1'b0;
      do_apply = (state_q == APPLY);
      if (rx_err) begin
         state_d = WAIT_B0;
      end else begin
         unique case (state_q)
            WAIT_B0, APPLY: begin
               // APPLY doubles as a sync hunt so a byte arriving right behind B2 is kept.
               if (rx_valid && rx_data[B0_SYNC]) begin
                  ld_b0   = 1'b1;
                  state_d = WAIT_B1;
               end else begin
                  state_d = WAIT_B0;
               end
            end
            WAIT_B1, WAIT_B2: begin
               if (rx_valid) begin
                  ld_b1   = (state_q == WAIT_B1);
                  ld_b2   = (state_q == WAIT_B2);
                  state_d = (state_q == WAIT_B1) ? WAIT_B2 : APPLY;
               end else if (tmo_q == TMO_LAST) begin
                  state_d = WAIT_B0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            default: state_d = WAIT_B0;
         endcase
      end
   end

   mouse_axis_accum #(.MAX(MAX_X)) u_x_accum (
      .pos      (mouse_xpos),
      .delta    ({b0_q.xsign, b1_q}),
      .ovf      (b0_q.xovf),
      .negate   (1'b0),
      .next_pos (x_next)
   );

   mouse_axis_accum #(.MAX(MAX_Y)) u_y_accum (
      .pos      (mouse_ypos),
      .delta    ({b0_q.ysign, b2_q}),
      .ovf      (b0_q.yovf),
      .negate   (1'b1),
      .next_pos (y_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= WAIT_B0;
         tmo_q        <= '0;
         mouse_xpos   <= COORD_W'(INIT_X);
         mouse_ypos   <= COORD_W'(INIT_Y);
         mouse_left   <= 1'b0;
         mouse_right  <= 1'b0;
         mouse_middle <= 1'b0;
         pkt_valid    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         pkt_valid <= do_apply;
         if (do_apply) begin
            mouse_xpos   <= x_next;
            mouse_ypos   <= y_next;
            mouse_left   <= b0_q.left;
            mouse_right  <= b0_q.right;
            mouse_middle <= b0_q.mid;
         end
      end
   end

   // NOTE: packet byte holders are always written before APPLY reads them, so they carry no reset.
   always_ff @(posedge pclk) begin
      if (ld_b0) b0_q <= b0_unpack(rx_data);
      if (ld_b1) b1_q <= rx_data;
      if (ld_b2) b2_q <= rx_data;
   end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder: packet decode, clamping, overflow,
// sync hunt, timeout, link error and mid-packet reset.
module tb_mouse_packet_decoder;

   localparam int TMO = 100;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_err;
   logic [11:0] mouse_xpos, mouse_ypos;
   logic        mouse_left, mouse_right, mouse_middle, pkt_valid;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int exp_pulses = 0;

   mouse_packet_decoder #(.TIMEOUT_CYC(TMO)) dut (
      .pclk         (pclk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_err       (rx_err),
      .mouse_xpos   (mouse_xpos),
      .mouse_ypos   (mouse_ypos),
      .mouse_left   (mouse_left),
      .mouse_right  (mouse_right),
      .mouse_middle (mouse_middle),
      .pkt_valid    (pkt_valid)
   );

   always #5 pclk = ~pclk;

   always @(negedge pclk) if (pkt_valid === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge pclk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_state(input string tag, input int ex, input int ey, input logic [2:0] btn);
      check({tag, "_x"}, 32'(mouse_xpos), ex);
      check({tag, "_y"}, 32'(mouse_ypos), ey);
      check({tag, "_btn"}, 32'({mouse_middle, mouse_right, mouse_left}), 32'(btn));
   endtask

   // Sends B0/B1/B2 (optional idle gap before B2), then checks the 2-cycle latency and result.
   task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int gap,
                      input int ex, input int ey, input logic [2:0] btn);
      send(b0);
      send(b1);
      if (gap > 0) idle(gap);
      send(b2);
      check({tag, "_pv_early"}, 32'(pkt_valid), 0);
      idle(1);
      exp_pulses++;
      check({tag, "_pv"}, 32'(pkt_valid), 1);
      check_state(tag, ex, ey, btn);
      idle(1);
      check({tag, "_pv_end"}, 32'(pkt_valid), 0);
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(10);
      check_state("reset", 400, 300, 3'b000);
      check("reset_pv", 32'(pkt_valid), 0);
      check("reset_pulses", 32'(pulses), 0);

      pkt("basic",   8'h09, 8'h0A, 8'h05, 0, 410, 295, 3'b001);
      pkt("xneg1",   8'h18, 8'h00, 8'h00, 0, 154, 295, 3'b000);
      pkt("xneg2",   8'h18, 8'h6B, 8'h00, 0,   5, 295, 3'b000);
      pkt("xclamp0", 8'h18, 8'h00, 8'h00, 0,   0, 295, 3'b000);
      pkt("xup1",    8'h08, 8'hFF, 8'h00, 0, 255, 295, 3'b000);
      pkt("xup2",    8'h08, 8'hFF, 8'h00, 0, 510, 295, 3'b000);
      pkt("xup3",    8'h08, 8'hBE, 8'h00, 0, 700, 295, 3'b000);
      for (int i = 0; i < 4; i++)
         pkt($sformatf("xmax%0d", i), 8'h08, 8'hFF, 8'h00, 0, 799, 295, 3'b000);
      pkt("xback",   8'h18, 8'h00, 8'h00, 0, 543, 295, 3'b000);

      send(8'h00);
      send(8'h07);
      pkt("hunt",    8'h08, 8'h01, 8'h01, 0, 544, 294, 3'b000);
      pkt("btns",    8'h0E, 8'h00, 8'h00, 0, 544, 294, 3'b110);

      send(8'h08);
      send(8'h05);
      idle(TMO + 10);
      pkt("timeout", 8'h08, 8'h02, 8'h00, 0, 546, 294, 3'b000);
      pkt("gap",     8'h08, 8'h03, 8'h00, TMO / 2, 549, 294, 3'b000);

      pkt("xovf",    8'h48, 8'h50, 8'h03, 0, 549, 291, 3'b000);
      pkt("yovf",    8'h88, 8'h02, 8'h50, 0, 551, 291, 3'b000);

      send(8'h08);
      send(8'h04);
      rx_err = 1'b1;
      idle(1);
      rx_err = 1'b0;
      pkt("rxerr",   8'h08, 8'h01, 8'h00, 0, 552, 291, 3'b000);

      pkt("ydown",   8'h28, 8'h00, 8'hF6, 0, 552, 301, 3'b000);
      pkt("ydown2",  8'h28, 8'h00, 8'h00, 0, 552, 557, 3'b000);
      pkt("ymax",    8'h28, 8'h00, 8'h00, 0, 552, 599, 3'b000);
      pkt("yup1",    8'h08, 8'h00, 8'hFF, 0, 552, 344, 3'b000);
      pkt("yup2",    8'h08, 8'h00, 8'hFF, 0, 552,  89, 3'b000);
      pkt("ymin",    8'h08, 8'h00, 8'hFF, 0, 552,   0, 3'b000);

      // Error and valid in the same cycle: the byte must be dropped.
      send(8'h08);
      rx_data = 8'h01; rx_valid = 1'b1; rx_err = 1'b1;
      idle(1);
      rx_valid = 1'b0; rx_err = 1'b0;
      pkt("errwins", 8'h08, 8'h01, 8'h00, 0, 553, 0, 3'b000);

      send(8'h09);
      send(8'h10);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      check_state("midrst", 400, 300, 3'b000);
      check("midrst_pv", 32'(pkt_valid), 0);
      pkt("postrst", 8'h08, 8'h01, 8'h00, 0, 401, 300, 3'b000);

      // Back-to-back packets: the next B0 lands in the APPLY cycle.
      send(8'h08); send(8'h01); send(8'h00);
      send(8'h08); send(8'h02); send(8'h00);
      idle(1);
      exp_pulses += 2;
      check("b2b_pv", 32'(pkt_valid), 1);
      check_state("b2b", 404, 300, 3'b000);
      idle(3);

      check("pulse_count", 32'(pulses), 32'(exp_pulses));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
